// File: rtl/disp_filter_pkg.sv
// Shared types and elaboration-time helpers for the
// disparity confidence weighting path.
package disp_filter_pkg;

  typedef enum logic [1:0] {
    SCALE = 2'd0,
    PASS  = 2'd1,
    GATE  = 2'd2
  } conf_mode_e;

  function automatic int recip(input int dec, input int frac);
    return (1 << frac) / (dec * dec);
  endfunction

  function automatic int popcount_w(input int dec);
    return $clog2(dec * dec + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with occupancy count;
// head word is visible on rdata whenever not empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 128
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] used,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = used == '0;
  assign full    = used == (AW+1)'(DEPTH);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write in the cycle it is popped.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      used <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   used <= used + (AW+1)'(1);
        2'b01:   used <= used - (AW+1)'(1);
        default: used <= used;
      endcase
    end
  end

endmodule

// File: rtl/disparity_conf_weighter.sv
// Gathers a DEC_FACTOR x DEC_FACTOR validity window and weights
// the window confidence by its valid-pixel count.
module disparity_conf_weighter
  import disp_filter_pkg::*;
#(
  parameter int DISP_BITS  = 5,
  parameter int CONF_BITS  = 8,
  parameter int DEC_FACTOR = 2,
  parameter int FRAC_BITS  = 16,
  parameter int FIFO_DEPTH = 128
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [DEC_FACTOR-1:0]     pixels_in,
  input  logic [DISP_BITS-1:0]      disp_in,
  input  logic [CONF_BITS-1:0]      conf_in,
  input  logic                      frame_start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                mode,
  input  logic [$clog2(DEC_FACTOR*DEC_FACTOR):0] conf_threshold,
  output logic [DISP_BITS+CONF_BITS-1:0] disp_conf_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      overflow
);

  localparam int N    = DEC_FACTOR * DEC_FACTOR;
  localparam int HW   = N - DEC_FACTOR;
  localparam int PW   = popcount_w(DEC_FACTOR);
  localparam int TW   = $clog2(N) + 1;
  localparam int RW   = $clog2(DEC_FACTOR);
  localparam int L    = $clog2(N);
  localparam int P    = 1 << L;
  localparam int RCP  = recip(DEC_FACTOR, FRAC_BITS);
  localparam int MW   = CONF_BITS + PW + FRAC_BITS;
  localparam int W    = DISP_BITS + CONF_BITS;
  localparam int UW   = $clog2(FIFO_DEPTH) + 1;
  localparam int CMAX = (1 << CONF_BITS) - 1;

  logic [DEC_FACTOR-1:0] row_bits;
  logic [HW-1:0]         win;
  logic [N-1:0]          win_next;
  logic [RW-1:0]         row;
  logic                  acc;
  logic                  last;
  logic                  complete;
  logic [PW-1:0]         pop_next;

  assign row_bits = ~pixels_in;
  assign win_next = {win, row_bits};
  assign acc      = in_valid && in_ready;
  assign last     = row == RW'(DEC_FACTOR - 1);
  assign complete = acc && !frame_start && last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row <= '0;
      win <= '0;
    end else if (acc) begin
      if (frame_start) begin
        row <= RW'(1);
        win <= HW'(row_bits);
      end else begin
        row <= last ? '0 : row + RW'(1);
        win <= win_next[HW-1:0];
      end
    end
  end

  // Balanced adder tree over the completed window.
  for (genvar l = 0; l <= L; l++) begin : g_lv
    logic [PW-1:0] s [0:(P>>l)-1];
    for (genvar i = 0; i < (P >> l); i++) begin : g_n
      if (l == 0) begin : g_leaf
        if (i < N) begin : g_bit
          assign s[i] = PW'(win_next[i]);
        end else begin : g_pad
          assign s[i] = '0;
        end
      end else begin : g_add
        assign s[i] = g_lv[l-1].s[2*i] + g_lv[l-1].s[2*i+1];
      end
    end
  end

  assign pop_next = g_lv[L].s[0];

  logic                 s1_valid;
  logic [PW-1:0]        s1_pop;
  logic [DISP_BITS-1:0] s1_disp;
  logic [CONF_BITS-1:0] s1_conf;
  logic [1:0]           s1_mode;
  logic [TW-1:0]        s1_thr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_pop   <= '0;
      s1_disp  <= '0;
      s1_conf  <= '0;
      s1_mode  <= '0;
      s1_thr   <= '0;
    end else begin
      s1_valid <= complete;
      if (complete) begin
        s1_pop  <= pop_next;
        s1_disp <= disp_in;
        s1_conf <= conf_in;
        s1_mode <= mode;
        s1_thr  <= conf_threshold;
      end
    end
  end

  logic [MW-1:0]        prod;
  logic [MW-1:0]        scaled;
  logic [CONF_BITS-1:0] res;
  logic                 gate_ok;

  assign gate_ok = 32'(s1_pop) >= 32'(s1_thr);

  always_comb begin
    prod   = MW'(s1_pop) * MW'(s1_conf) * MW'(RCP);
    scaled = prod >> FRAC_BITS;
    res    = s1_conf;
    unique case (1'b1)
      (s1_mode == PASS): res = s1_conf;
      (s1_mode == GATE): res = gate_ok ? s1_conf : '0;
      default: begin
        // A fully valid window bypasses the truncating reciprocal.
        if (s1_pop != PW'(N)) begin
          if (scaled > MW'(CMAX)) res = CONF_BITS'(CMAX);
          else res = scaled[CONF_BITS-1:0];
        end
      end
    endcase
  end

  logic         s2_valid;
  logic [W-1:0] s2_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_data <= {s1_disp, res};
    end
  end

  logic [W-1:0]  rdata;
  logic [UW-1:0] used;
  logic          full;
  logic          empty;
  logic          fifo_pop;
  logic [UW:0]   occ;

  assign fifo_pop = out_valid && out_ready;

  sync_fifo_fwft #(
    .WIDTH(W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (s2_valid),
    .wdata  (s2_data),
    .pop    (fifo_pop),
    .rdata  (rdata),
    .used   (used),
    .full   (full),
    .empty  (empty)
  );

  // Results already in the pipe reserve a FIFO slot.
  assign occ = (UW+1)'(used) + (UW+1)'(s1_valid)
             + (UW+1)'(s2_valid);
  assign in_ready      = occ < (UW+1)'(FIFO_DEPTH);
  assign out_valid     = !empty;
  assign disp_conf_out = empty ? '0 : rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (s2_valid && full && !fifo_pop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_disparity_conf_weighter.sv
// Directed bench for disparity_conf_weighter at D=2
// plus a D=3 instance for the reciprocal path.
module tb_disparity_conf_weighter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  pixels_in;
  logic [4:0]  disp_in;
  logic [7:0]  conf_in;
  logic        frame_start;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mode;
  logic [2:0]  conf_threshold;
  logic [12:0] disp_conf_out;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;

  logic [2:0]  p3;
  logic        in_valid3;
  logic        in_ready3;
  logic [4:0]  thr3;
  logic [12:0] out3;
  logic        out_valid3;
  logic        out_ready3;
  logic        overflow3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  disparity_conf_weighter dut (
    .clk(clk), .reset_n(reset_n),
    .pixels_in(pixels_in), .disp_in(disp_in),
    .conf_in(conf_in), .frame_start(frame_start),
    .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .conf_threshold(conf_threshold),
    .disp_conf_out(disp_conf_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow)
  );

  disparity_conf_weighter #(.DEC_FACTOR(3)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .pixels_in(p3), .disp_in(disp_in),
    .conf_in(conf_in), .frame_start(frame_start),
    .in_valid(in_valid3), .in_ready(in_ready3),
    .mode(mode), .conf_threshold(thr3),
    .disp_conf_out(out3),
    .out_valid(out_valid3), .out_ready(out_ready3),
    .overflow(overflow3)
  );

  typedef struct {
    logic [1:0] r0;
    logic [1:0] r1;
    logic [4:0] d;
    logic [7:0] c;
    logic [1:0] m;
    logic [2:0] th;
    logic [7:0] e;
  } vec_t;

  vec_t tv [11];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic beat(input logic [1:0] pix,
                      input logic fs,
                      input logic [4:0] d,
                      input logic [7:0] c,
                      input logic [1:0] m,
                      input logic [2:0] th);
    int n = 0;
    pixels_in = pix; frame_start = fs;
    disp_in = d; conf_in = c; mode = m;
    conf_threshold = th; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk); n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL beat_ready: in_ready got 0 required 1");
    end
    @(negedge clk);
    in_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic try_beat(input logic [1:0] pix,
                          input logic [4:0] d,
                          input logic [7:0] c,
                          output bit ok);
    int n = 0;
    pixels_in = pix; frame_start = 1'b0;
    disp_in = d; conf_in = c; mode = 2'd0;
    conf_threshold = '0; in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk); n++;
    end
    ok = in_ready;
    if (ok) @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic take(input string nm,
                      input logic [12:0] exp,
                      input int lat);
    int n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk); n++;
    end
    check({nm, "_valid"}, out_valid, 1);
    check({nm, "_lat"}, n, lat);
    check({nm, "_data"}, disp_conf_out, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({nm, "_empty"}, out_valid, 0);
  endtask

  task automatic beat3(input logic [2:0] pix,
                       input logic [4:0] d,
                       input logic [7:0] c);
    p3 = pix; disp_in = d; conf_in = c;
    mode = 2'd0; in_valid3 = 1'b1;
    @(negedge clk);
    in_valid3 = 1'b0;
  endtask

  task automatic take3(input string nm,
                       input logic [12:0] exp);
    int n = 0;
    while (!out_valid3 && n < 50) begin
      @(negedge clk); n++;
    end
    check({nm, "_valid"}, out_valid3, 1);
    check({nm, "_data"}, out3, exp);
    out_ready3 = 1'b1;
    @(negedge clk);
    out_ready3 = 1'b0;
  endtask

  initial begin
    bit ok0;
    bit ok1;
    int accepted;
    int n;

    tv[0]  = '{2'b00, 2'b01, 5'd7,  8'd200, 2'd0, 3'd0, 8'd150};
    tv[1]  = '{2'b00, 2'b00, 5'd3,  8'd255, 2'd0, 3'd0, 8'd255};
    tv[2]  = '{2'b11, 2'b00, 5'd4,  8'd90,  2'd2, 3'd3, 8'd0};
    tv[3]  = '{2'b00, 2'b00, 5'd5,  8'd90,  2'd2, 3'd3, 8'd90};
    tv[4]  = '{2'b11, 2'b11, 5'd6,  8'd90,  2'd1, 3'd3, 8'd90};
    tv[5]  = '{2'b11, 2'b11, 5'd8,  8'd200, 2'd0, 3'd0, 8'd0};
    tv[6]  = '{2'b01, 2'b10, 5'd9,  8'd201, 2'd0, 3'd0, 8'd100};
    tv[7]  = '{2'b10, 2'b00, 5'd10, 8'd100, 2'd3, 3'd0, 8'd75};
    tv[8]  = '{2'b00, 2'b01, 5'd11, 8'd50,  2'd2, 3'd3, 8'd50};
    tv[9]  = '{2'b11, 2'b11, 5'd12, 8'd17,  2'd2, 3'd0, 8'd17};
    tv[10] = '{2'b11, 2'b01, 5'd13, 8'd255, 2'd0, 3'd0, 8'd63};

    reset_n = 1'b0;
    pixels_in = '0; disp_in = '0; conf_in = '0;
    frame_start = 1'b0; in_valid = 1'b0; mode = '0;
    conf_threshold = '0; out_ready = 1'b0;
    p3 = '0; in_valid3 = 1'b0; thr3 = '0; out_ready3 = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_data", disp_conf_out, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid3", out_valid3, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 11; k++) begin
      beat(tv[k].r0, 1'b0, tv[k].d, tv[k].c, tv[k].m, tv[k].th);
      beat(tv[k].r1, 1'b0, tv[k].d, tv[k].c, tv[k].m, tv[k].th);
      take($sformatf("vec%0d", k), {tv[k].d, tv[k].e}, 2);
    end

    beat(2'b11, 1'b1, 5'd20, 8'd200, 2'd0, 3'd0);
    beat(2'b00, 1'b1, 5'd20, 8'd200, 2'd0, 3'd0);
    beat(2'b00, 1'b0, 5'd21, 8'd200, 2'd0, 3'd0);
    take("frame", {5'd21, 8'd200}, 2);

    beat3(3'b000, 5'd9, 8'd255);
    beat3(3'b000, 5'd9, 8'd255);
    beat3(3'b000, 5'd9, 8'd255);
    take3("d3_full", {5'd9, 8'd255});
    beat3(3'b000, 5'd2, 8'd255);
    beat3(3'b000, 5'd2, 8'd255);
    beat3(3'b001, 5'd2, 8'd255);
    take3("d3_pop8", {5'd2, 8'd226});

    accepted = 0;
    for (int w = 0; w < 300; w++) begin
      try_beat(2'b00, w[4:0], w[7:0], ok0);
      if (!ok0) break;
      try_beat(2'b00, w[4:0], w[7:0], ok1);
      if (!ok1) break;
      accepted++;
    end
    check("bp_accepted", accepted, 128);
    check("bp_in_ready", in_ready, 0);
    check("bp_overflow", overflow, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 128; k++) begin
      n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk); n++;
      end
      check($sformatf("drain%0d", k), disp_conf_out,
            {k[4:0], k[7:0]});
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("drain_empty", out_valid, 0);
    check("drain_in_ready", in_ready, 1);
    check("drain_overflow", overflow, 0);

    for (int k = 0; k < 5; k++) begin
      beat(2'b00, 1'b0, 5'(k), 8'(k + 40), 2'd0, 3'd0);
      beat(2'b00, 1'b0, 5'(k), 8'(k + 40), 2'd0, 3'd0);
    end
    repeat (4) @(negedge clk);
    check("pre_rst_valid", out_valid, 1);
    beat(2'b11, 1'b0, 5'd1, 8'd1, 2'd0, 3'd0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", disp_conf_out, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_valid", out_valid, 0);
    beat(2'b00, 1'b0, 5'd30, 8'd100, 2'd0, 3'd0);
    beat(2'b01, 1'b0, 5'd30, 8'd100, 2'd0, 3'd0);
    take("post_rst", {5'd30, 8'd75}, 2);
    check("end_overflow", overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
